// File: rtl/msg_pkg.sv
// Shared types and constants for the message-stream blocks.
package msg_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Bits per byte; used to size tkeep from the data width.
  localparam int BYTE_LEN = 8;

  // Longest legal message in beats (32 bytes over an 8-byte bus).
  localparam int MAX_BEATS_DEF = 4;

endpackage

// File: rtl/msg_stream_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping around.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  int idx;

  // Scan from ptr upward, taking the first set request.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_stream_arb.sv
// Message-granular round-robin arbiter for AXI-stream requesters.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ARB_IDLE   | no grant held; pick next valid requester (no beat accepted)
//   ARB_LOCKED | grant held; forward beats until tlast (or drop after overlong)
module msg_stream_arb
  import msg_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int TDATA_WIDTH = 64,
  parameter int MAX_BEATS   = MAX_BEATS_DEF
) (
  input  logic                                   clk,
  input  logic                                   sreset,
  input  logic [NUM_IN-1:0]                      axis_in_tvalid,
  output logic [NUM_IN-1:0]                      axis_in_tready,
  input  logic [NUM_IN*TDATA_WIDTH-1:0]          axis_in_tdata,
  input  logic [NUM_IN*TDATA_WIDTH/BYTE_LEN-1:0] axis_in_tkeep,
  input  logic [NUM_IN-1:0]                      axis_in_tlast,
  output logic                                   axis_out_tvalid,
  input  logic                                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                 axis_out_tdata,
  output logic [TDATA_WIDTH/BYTE_LEN-1:0]        axis_out_tkeep,
  output logic                                   axis_out_tlast,
  output logic [$clog2(NUM_IN)-1:0]              axis_out_tid,
  output logic                                   overlong_err,
  output logic [15:0]                            msg_total
);

  localparam int KEEP_W = TDATA_WIDTH / BYTE_LEN;
  localparam int IDX_W  = $clog2(NUM_IN);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, rr_ptr_q, pick_idx, grant_next;
  logic [2:0]              beat_cnt_q;
  logic                    drop_q;
  logic [NUM_IN-1:0]       pick_gnt;
  logic                    pick_valid;
  logic                    out_space, accept, fwd, force_end, beat_hit_max, end_last;
  logic                    sel_valid, sel_last;
  logic [TDATA_WIDTH-1:0]  sel_data;
  logic [KEEP_W-1:0]       sel_keep;

  rr_pick #(.N(NUM_IN), .PTR_W(IDX_W)) u_rr_pick (
    .req   (axis_in_tvalid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // One-hot grant to index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  assign sel_valid    = axis_in_tvalid[grant_q];
  assign sel_last     = axis_in_tlast[grant_q];
  assign sel_data     = axis_in_tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
  assign sel_keep     = axis_in_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
  assign out_space    = !axis_out_tvalid || axis_out_tready;
  assign beat_hit_max = (beat_cnt_q + 3'd1) == 3'(MAX_BEATS);
  assign fwd          = accept && !drop_q;
  assign force_end    = fwd && !sel_last && beat_hit_max;
  assign end_last     = sel_last || beat_hit_max;
  assign grant_next   = (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;

  // Next state, per-requester ready and beat acceptance.
  always_comb begin
    state_d        = state_q;
    axis_in_tready = '0;
    accept         = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        axis_in_tready[grant_q] = out_space;
        accept = sel_valid && out_space;
        if (accept && sel_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant, pointer, beat counter, drop flag and message count.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      drop_q     <= 1'b0;
      msg_total  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && pick_valid) begin
        grant_q    <= pick_idx;
        beat_cnt_q <= '0;
        drop_q     <= 1'b0;
      end
      if (fwd) beat_cnt_q <= beat_cnt_q + 3'd1;
      if (force_end) drop_q <= 1'b1;
      if (accept && sel_last) begin
        rr_ptr_q   <= grant_next;
        beat_cnt_q <= '0;
        drop_q     <= 1'b0;
        if (!drop_q) msg_total <= msg_total + 16'd1;
      end
    end
  end

  // Output register: load on forward, hold while stalled, empty on drain.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      axis_out_tvalid <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tid    <= '0;
      overlong_err    <= 1'b0;
    end else begin
      overlong_err <= force_end;
      if (fwd) begin
        axis_out_tvalid <= 1'b1;
        axis_out_tdata  <= sel_data;
        axis_out_tlast  <= end_last;
        axis_out_tkeep  <= end_last ? sel_keep : '0;
        axis_out_tid    <= grant_q;
      end else if (axis_out_tready) begin
        axis_out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/msg_stream_arb.md
MSG_STREAM_ARB -- requirements
Module: msg_stream_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, the number of requester streams (2..8).
REQ-002 SHALL have parameter TDATA_WIDTH, default 64, the data width per stream, a multiple of 8.
REQ-003 SHALL have parameter MAX_BEATS, default 4, the longest legal message in beats (32 bytes / 8).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port sreset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port axis_in_tvalid, input, NUM_IN bits: per-requester valid.
REQ-007 SHALL have port axis_in_tready, output, NUM_IN bits: per-requester ready.
REQ-008 SHALL have port axis_in_tdata, input, NUM_IN*TDATA_WIDTH bits: data; requester i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH].
REQ-009 SHALL have port axis_in_tkeep, input, NUM_IN*TDATA_WIDTH/8 bits: valid-byte count on the last beat, with 0 meaning all bytes valid.
REQ-010 SHALL have port axis_in_tlast, input, NUM_IN bits: end of message.
REQ-011 SHALL have port axis_out_tvalid, output, 1 bit.
REQ-012 SHALL have port axis_out_tready, input, 1 bit.
REQ-013 SHALL have ports axis_out_tdata, axis_out_tkeep and axis_out_tlast, outputs: the granted beat, registered.
REQ-014 SHALL have port axis_out_tid, output, $clog2(NUM_IN) bits: the index of the granted requester.
REQ-015 SHALL have port overlong_err, output, 1 bit: one-cycle pulse on a forced message termination.
REQ-016 SHALL have port msg_total, output, 16 bits: count of messages forwarded, wrapping.

Function
REQ-017 SHALL use an FSM with two states: ARB_IDLE and ARB_LOCKED.
REQ-018 In ARB_IDLE, with any axis_in_tvalid set, SHALL grant the first valid requester at or after rr_ptr (wrap-around search), latch the grant and go to ARB_LOCKED the next cycle; grant decision takes 1 cycle and no beat is accepted in ARB_IDLE.
REQ-019 In ARB_LOCKED, axis_in_tready[g] SHALL equal (!axis_out_tvalid | axis_out_tready); all other tready bits SHALL be 0.
REQ-020 An accepted input beat SHALL appear on the output register the next cycle (latency 1); a full output register SHALL hold all its fields stable until axis_out_tready is sampled high.
REQ-021 The grant SHALL remain fixed until a beat with tlast is accepted; then rr_ptr SHALL become (g+1) mod NUM_IN, msg_total SHALL increment and the FSM SHALL return to ARB_IDLE.
REQ-022 A 3-bit beat counter SHALL count accepted beats of the current message.
REQ-023 On acceptance of beat MAX_BEATS without tlast, the block SHALL force axis_out_tlast=1 on that beat, pulse overlong_err, drop the requester's remaining beats up to and including its tlast (tready high, nothing forwarded), then return to ARB_IDLE without incrementing msg_total.
REQ-024 axis_out_tkeep SHALL pass through unchanged on the last beat and SHALL be 0 on non-last beats.
REQ-025 A requester deasserting tvalid mid-message SHALL NOT release the grant; the block SHALL wait.
REQ-026 Back-to-back messages from different requesters SHALL incur exactly one idle input cycle (the ARB_IDLE grant cycle).
REQ-027 msg_total SHALL wrap from 16'hFFFF to 0.

Reset
REQ-028 Asserting sreset SHALL immediately force ARB_IDLE, rr_ptr=0, beat counter=0, axis_out_tvalid=0, axis_out_tdata/tkeep/tlast/tid=0, overlong_err=0, msg_total=0 and axis_in_tready=0, including when reset arrives mid-message; any partial message is discarded.
REQ-029 After sreset deasserts, the first grant SHALL be evaluated on the first clk edge.

Structure
REQ-030 The FSM state enum, the 8-bit byte-length constant and the MAX_BEATS default SHALL live in a shared package, msg_pkg, also used by the message-extraction blocks.
REQ-031 The round-robin search SHALL be one sub-module, rr_pick (inputs: request vector and pointer; output: one-hot grant plus valid), purely combinational.

Verification
REQ-032 Requesters 0 and 2 each present a 2-beat message at reset release -> output carries req 0 (tid=0) beats, then req 2 (tid=2); msg_total=2.
REQ-033 All 4 requesters continuously valid with 1-beat messages -> grant order 0,1,2,3,0; each output beat separated by one idle cycle.
REQ-034 Granted requester 1 sends 3 beats while axis_out_tready is toggled 1,0,0,1 -> no beat lost or duplicated, and output fields stay stable while stalled.
REQ-035 Requester 3 sends 6 beats with tlast on beat 6 -> 4 beats are forwarded with tlast on beat 4, overlong_err pulses once, beats 5-6 are dropped, and msg_total is unchanged.
REQ-036 sreset asserted mid-message after beat 2 -> outputs are 0 immediately; after release a new message from requester 0 is forwarded cleanly with tid=0.
REQ-037 Last beat with tkeep=5 -> axis_out_tkeep=5 with axis_out_tlast=1; earlier beats show tkeep=0.
